// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: start, DATA_WIDTH data bits, optional parity, one or two stop bits, one bit per CLK.
// Define UART_TX_HOLD_BUF_EN to add a one-word hold buffer that chains frames with no idle gap.
module uart_tx_frame_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  TX_OUT
);

    localparam int unsigned   CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state_r;
    logic [CW-1:0]         bit_cnt_r;
    logic                  stop_cnt_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  stop2_r;

    logic                  accept;
    logic                  last_stop;
    logic                  load_in;
    logic                  load_buf;
    logic                  load;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_par_en;
    logic                  ld_par_typ;
    logic                  ld_stop2;
    logic [CW-1:0]         bit_idx;
    logic                  par_bit;

    assign accept     = Data_valid && ready;
    assign last_stop  = (state_r == STOP) && (stop_cnt_r == stop2_r);
    assign load       = load_in || load_buf;
    assign busy       = (state_r != IDLE);
    assign frame_done = last_stop;

`ifdef UART_TX_HOLD_BUF_EN
    logic                  hb_valid_r;
    logic [DATA_WIDTH-1:0] hb_data_r;
    logic                  hb_par_en_r;
    logic                  hb_par_typ_r;
    logic                  hb_stop2_r;

    assign ready = ~hb_valid_r;

    // A word arriving while a frame runs parks in the buffer unless this is
    // the final stop cycle, where it chains straight into START instead.
    always_comb begin
        load_buf   = last_stop && hb_valid_r;
        load_in    = accept && ((state_r == IDLE) || last_stop);
        ld_data    = load_buf ? hb_data_r    : P_DATA;
        ld_par_en  = load_buf ? hb_par_en_r  : PAR_EN;
        ld_par_typ = load_buf ? hb_par_typ_r : PAR_TYP;
        ld_stop2   = load_buf ? hb_stop2_r   : STOP2;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hb_valid_r   <= 1'b0;
            hb_data_r    <= '0;
            hb_par_en_r  <= 1'b0;
            hb_par_typ_r <= 1'b0;
            hb_stop2_r   <= 1'b0;
        end else if (load_buf) begin
            hb_valid_r <= 1'b0;
        end else if (accept && !load_in) begin
            hb_valid_r   <= 1'b1;
            hb_data_r    <= P_DATA;
            hb_par_en_r  <= PAR_EN;
            hb_par_typ_r <= PAR_TYP;
            hb_stop2_r   <= STOP2;
        end
    end
`else
    assign ready = (state_r == IDLE);

    always_comb begin
        load_buf   = 1'b0;
        load_in    = accept;
        ld_data    = P_DATA;
        ld_par_en  = PAR_EN;
        ld_par_typ = PAR_TYP;
        ld_stop2   = STOP2;
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            data_r     <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stop2_r    <= 1'b0;
        end else begin
            if (load) begin
                data_r    <= ld_data;
                par_en_r  <= ld_par_en;
                par_typ_r <= ld_par_typ;
                stop2_r   <= ld_stop2;
            end
            case (state_r)
                IDLE: begin
                    if (load) state_r <= START;
                end
                START: begin
                    bit_cnt_r <= '0;
                    state_r   <= DATA;
                end
                DATA: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_r  <= '0;
                        stop_cnt_r <= 1'b0;
                        state_r    <= par_en_r ? PARITY : STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                    end
                end
                PARITY: begin
                    stop_cnt_r <= 1'b0;
                    state_r    <= STOP;
                end
                STOP: begin
                    if (last_stop) begin
                        stop_cnt_r <= 1'b0;
                        state_r    <= load ? START : IDLE;
                    end else begin
                        stop_cnt_r <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // The latched word stays intact for the whole frame, so parity reads it directly.
    always_comb begin
        bit_idx = LSB_FIRST ? bit_cnt_r : (LAST_BIT - bit_cnt_r);
        par_bit = par_typ_r ? ~(^data_r) : (^data_r);
        case (state_r)
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = data_r[bit_idx];
            PARITY:  TX_OUT = par_bit;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for uart_tx_frame_serializer: three instances (W8 LSB, W8 MSB, W5 LSB)
// checked every cycle against a frame-queue model, plus literal frame patterns.
module tb_uart_tx_frame_serializer;

    localparam int HN = 8192;

    typedef struct packed {
        logic tx;
        logic done;
    } ent_t;

    logic        CLK;
    logic        RST;
    logic [2:0]  dv, pe, pt, s2;
    logic [2:0]  rdy, bsy, fd, txo;
    logic [15:0] pd [3];

    ent_t        mq [3][$];
    bit          last_acc [3];
    int          acc_cyc [3];
    int          cyc;
    logic [3:0]  hist [3][HN];
    int          checks;
    int          failures;

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[0][7:0]), .Data_valid(dv[0]), .PAR_EN(pe[0]),
        .PAR_TYP(pt[0]), .STOP2(s2[0]), .ready(rdy[0]), .busy(bsy[0]),
        .frame_done(fd[0]), .TX_OUT(txo[0]));

    uart_tx_frame_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[1][7:0]), .Data_valid(dv[1]), .PAR_EN(pe[1]),
        .PAR_TYP(pt[1]), .STOP2(s2[1]), .ready(rdy[1]), .busy(bsy[1]),
        .frame_done(fd[1]), .TX_OUT(txo[1]));

    uart_tx_frame_serializer #(.DATA_WIDTH(5), .LSB_FIRST(1'b1)) dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[2][4:0]), .Data_valid(dv[2]), .PAR_EN(pe[2]),
        .PAR_TYP(pt[2]), .STOP2(s2[2]), .ready(rdy[2]), .busy(bsy[2]),
        .frame_done(fd[2]), .TX_OUT(txo[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int wid(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic bit lsbf(input int k);
        return (k != 1);
    endfunction

    // Expected line sequence of one frame, built from the framing rules.
    task automatic push_frame(input int k, input logic [15:0] d, input logic p_e,
                              input logic p_t, input logic s_2);
        ent_t e;
        int   w;
        int   ones;
        w    = wid(k);
        ones = 0;
        e.tx = 1'b0; e.done = 1'b0;
        mq[k].push_back(e);
        for (int i = 0; i < w; i++) begin
            e.tx = lsbf(k) ? d[i] : d[w-1-i];
            mq[k].push_back(e);
            if (d[i]) ones++;
        end
        if (p_e) begin
            e.tx = ((ones % 2) == 1) ^ p_t;
            mq[k].push_back(e);
        end
        e.tx = 1'b1;
        if (s_2) mq[k].push_back(e);
        e.done = 1'b1;
        mq[k].push_back(e);
    endtask

    function automatic int nframes(input int k);
        int n = 0;
        for (int i = 0; i < mq[k].size(); i++) if (mq[k][i].done) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int k);
`ifdef UART_TX_HOLD_BUF_EN
        return nframes(k) <= 1;
`else
        return nframes(k) == 0;
`endif
    endfunction

    task automatic cmp1(input string nm, input int k, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%b exp=%b", nm, k, cyc, got, exp);
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h exp=%h", nm, k, got, exp);
        end
    endtask

    // f: 3=TX_OUT 2=busy 1=ready 0=frame_done; first cycle lands in the MSB of the n bits.
    function automatic logic [31:0] hseq(input int k, input int start, input int n, input int f);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], hist[k][(start + i) % HN][f]};
        return v;
    endfunction

    // Monitor: advance the model on each edge, then compare all outputs.
    initial begin
        bit acc;
        logic e_tx, e_fd, e_b;
        cyc = 0;
        forever begin
            @(posedge CLK);
            for (int k = 0; k < 3; k++) begin
                acc = 1'b0;
                if (!RST) begin
                    mq[k].delete();
                end else begin
                    acc = dv[k] && m_ready(k);
                    if (mq[k].size() > 0) void'(mq[k].pop_front());
                    if (acc) push_frame(k, pd[k], pe[k], pt[k], s2[k]);
                end
                last_acc[k] = acc;
                if (acc) acc_cyc[k] = cyc;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                e_b  = (mq[k].size() > 0);
                e_tx = e_b ? mq[k][0].tx : 1'b1;
                e_fd = e_b ? mq[k][0].done : 1'b0;
                cmp1("mon_tx", k, txo[k], e_tx);
                cmp1("mon_busy", k, bsy[k], e_b);
                cmp1("mon_ready", k, rdy[k], m_ready(k));
                cmp1("mon_frame_done", k, fd[k], e_fd);
                hist[k][cyc % HN] = {txo[k], bsy[k], rdy[k], fd[k]};
            end
            cyc++;
        end
    end

    // Call at a negedge; returns at the negedge following acceptance with inputs scrambled.
    task automatic offer(input int k, input logic [15:0] d, input logic p_e, input logic p_t,
                         input logic s_2, output int acyc);
        int n;
        n = 0;
        pd[k] = d; pe[k] = p_e; pt[k] = p_t; s2[k] = s_2; dv[k] = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!last_acc[k] && n < 200);
        checks++;
        if (!last_acc[k]) begin
            failures++;
            $display("FAIL offer_timeout inst=%0d got=no_accept exp=accept", k);
        end
        acyc  = acc_cyc[k];
        dv[k] = 1'b0;
        pd[k] = 16'($urandom);
        pe[k] = 1'($urandom);
        pt[k] = 1'($urandom);
        s2[k] = 1'($urandom);
    endtask

    task automatic rand_run(input int k, input int nf);
        int a;
        for (int i = 0; i < nf; i++) begin
            offer(k, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
    endtask

    initial begin
        int a, a2, rel;
        checks = 0; failures = 0;
        RST = 1'b0; dv = '0; pe = '0; pt = '0; s2 = '0;
        for (int k = 0; k < 3; k++) pd[k] = '0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("reset_tx", k, 32'(txo[k]), 32'd1);
            chk("reset_busy", k, 32'(bsy[k]), 32'd0);
            chk("reset_ready", k, 32'(rdy[k]), 32'd1);
            chk("reset_frame_done", k, 32'(fd[k]), 32'd0);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        offer(0, 16'hA5, 1'b0, 1'b0, 1'b0, a);
        repeat (12) @(negedge CLK);
        chk("a5_tx", 0, hseq(0, a, 11, 3), 32'(11'b01010010111));
        chk("a5_busy", 0, hseq(0, a, 11, 2), 32'(11'b11111111110));
        chk("a5_done", 0, hseq(0, a, 11, 0), 32'(11'b00000000010));

        offer(0, 16'hA5, 1'b1, 1'b0, 1'b0, a);
        repeat (13) @(negedge CLK);
        chk("a5_even_tx", 0, hseq(0, a, 12, 3), 32'(12'b010100101011));
        chk("a5_even_done", 0, hseq(0, a, 12, 0), 32'(12'b000000000010));

        offer(0, 16'hA5, 1'b1, 1'b1, 1'b1, a);
        repeat (14) @(negedge CLK);
        chk("a5_odd_stop2_tx", 0, hseq(0, a, 13, 3), 32'(13'b0101001011111));
        chk("a5_odd_stop2_busy", 0, hseq(0, a, 13, 2), 32'(13'b1111111111110));
        chk("a5_odd_stop2_done", 0, hseq(0, a, 13, 0), 32'(13'b0000000000010));

        offer(1, 16'h01, 1'b0, 1'b0, 1'b0, a);
        repeat (12) @(negedge CLK);
        chk("msb_01_tx", 1, hseq(1, a, 11, 3), 32'(11'b00000000111));

        offer(2, 16'h13, 1'b0, 1'b0, 1'b0, a);
        repeat (9) @(negedge CLK);
        chk("w5_13_tx", 2, hseq(2, a, 8, 3), 32'(8'b01100111));

        offer(0, 16'h00, 1'b0, 1'b0, 1'b0, a);
        offer(0, 16'hFF, 1'b0, 1'b0, 1'b0, a2);
        repeat (24) @(negedge CLK);
`ifdef UART_TX_HOLD_BUF_EN
        chk("b2b_accept_gap", 0, 32'(a2 - a), 32'd1);
        chk("b2b_tx", 0, hseq(0, a, 20, 3), 32'(20'b00000000010111111111));
        chk("b2b_busy", 0, hseq(0, a, 20, 2), 32'(20'hFFFFF));
        chk("b2b_ready", 0, hseq(0, a, 11, 1), 32'(11'b10000000001));
`else
        chk("b2b_accept_gap", 0, 32'(a2 - a), 32'd11);
        chk("b2b_tx", 0, hseq(0, a, 21, 3), 32'(21'b000000000110111111111));
        chk("b2b_ready", 0, hseq(0, a, 11, 1), 32'(11'b00000000001));
`endif

        offer(0, 16'h5A, 1'b1, 1'b0, 1'b0, a);
        pd[0] = 16'h3C; dv[0] = 1'b1;
        repeat (4) @(posedge CLK);
        #2;
`ifdef UART_TX_HOLD_BUF_EN
        chk("rst_pre_ready", 0, 32'(rdy[0]), 32'd0);
`endif
        #1;
        RST = 1'b0; dv[0] = 1'b0;
        #1;
        chk("rst_async_tx", 0, 32'(txo[0]), 32'd1);
        chk("rst_async_busy", 0, 32'(bsy[0]), 32'd0);
        chk("rst_async_ready", 0, 32'(rdy[0]), 32'd1);
        chk("rst_async_done", 0, 32'(fd[0]), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        rel = cyc;
        repeat (17) @(negedge CLK);
        chk("rst_after_busy", 0, hseq(0, rel, 16, 2), 32'd0);
        chk("rst_after_tx", 0, hseq(0, rel, 16, 3), 32'hFFFF);

        fork
            rand_run(0, 120);
            rand_run(1, 120);
            rand_run(2, 120);
        join
        repeat (30) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_frame_serializer.md
# uart_tx_frame_serializer

Parametrised UART transmit engine: accepts a parallel word on a valid/ready handshake and emits a complete serial frame (start, data, optional parity, one or two stop bits) at one bit per CLK cycle. It replaces the bare data-bit shifter in the UART TX path. CLK is the TX bit clock, so no internal prescaler is needed. Start/stop/parity framing, runtime frame options, bit order and optional back-to-back buffering are all contained in this block.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..16.
- LSB_FIRST, 1, 1 = data LSB transmitted first, 0 = MSB first.

- CLK  input  1  TX bit clock; all logic on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  word to transmit; sampled on acceptance.
- Data_valid  input  1  word offered; accepted on a rising edge where Data_valid && ready.
- PAR_EN  input  1  1 = append parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- STOP2  input  1  0 = one stop bit, 1 = two; sampled on acceptance.
- ready  output  1  block can accept a word this cycle.
- busy  output  1  frame in progress.
- frame_done  output  1  high during the final stop-bit cycle of each frame.
- TX_OUT  output  1  serial line; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1. On acceptance, latch P_DATA, PAR_EN, PAR_TYP and STOP2 into the frame registers, then go to START.
- START: TX_OUT=0 for one cycle, then go to DATA.
- DATA: DATA_WIDTH cycles, one bit per cycle, in the order set by LSB_FIRST.
  - Bit counter width is $clog2(DATA_WIDTH); it runs 0..DATA_WIDTH-1.
  - On the last data bit, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: one cycle.
  - TX_OUT = ^data when even; ~^data when odd.
  - Parity is computed from the latched word, never from live P_DATA.
- STOP: TX_OUT=1 for 1 cycle, or 2 cycles if the latched STOP2=1. frame_done is high in the last of these cycles.
- Frame length is 2 + DATA_WIDTH + PAR_EN + STOP2 cycles.
- Changes to P_DATA, PAR_EN, PAR_TYP or STOP2 after acceptance do not affect the frame in flight.
- Data_valid while ready=0 is ignored. The word is neither lost silently into the FSM nor queued; the source must hold it.

## Timing
- Reset values: TX_OUT=1, busy=0, ready=1, frame_done=0. FSM=IDLE, counters and registers zero.
- Reset asserted mid-frame aborts immediately: TX_OUT returns to 1 asynchronously and a buffered word is discarded.
- Latency: acceptance at edge N gives start bit on TX_OUT from N to N+1. All outputs are registered or decoded from registered state only.
- busy rises the cycle after acceptance and stays high through the final stop-bit cycle.
- ready and frame_done are combinational decodes of registered state, with no input-to-output paths.

## Configuration
- Macro: UART_TX_HOLD_BUF_EN.
- Defined: a one-word hold buffer, which stores data plus the three option bits.
  - ready = hold buffer empty, so a word can be accepted while busy.
  - If the hold buffer is full in the final stop-bit cycle, the FSM goes directly to START with the buffered word. There is zero idle gap and busy stays high.
  - Acceptance in the final stop cycle with the buffer empty is also chained with no gap.
  - In IDLE with the buffer empty, acceptance goes straight to START and the buffer is not used.
- Undefined: no hold buffer; ready = (state==IDLE).
  - Consecutive frames are separated by at least one idle-high cycle.

## Test plan
- W=8, LSB_FIRST=1, 0xA5, PAR_EN=0, STOP2=0: TX_OUT from the cycle after acceptance is 0,1,0,1,0,0,1,0,1,1, i.e. start, data 1,0,1,0,0,1,0,1, stop. busy is high for 10 cycles and frame_done pulses on cycle 10.
- 0xA5 with PAR_EN=1: even parity gives parity bit 0, odd parity gives 1. Frame is 11 cycles; STOP2=1 makes it 12, with frame_done on the second stop bit only.
- LSB_FIRST=0, W=8, 0x01: TX_OUT is 0, 0,0,0,0,0,0,0,1, 1. For W=5, 0x13 LSB first: 0, 1,1,0,0,1, 1.
- With the macro defined, offer 0x00 then 0xFF back-to-back: 20 contiguous cycles, 0 ×9, 1, 0, 1 ×8, 1, with no idle cycle between frames. Without the macro, ready is low during frame 1 and a 1-cycle idle gap appears.
- Assert RST in data bit 3 of a frame while a word is buffered: TX_OUT=1, busy=0, ready=1 immediately. After release no frame is sent until a new acceptance.
- Change P_DATA and PAR_TYP mid-frame: the transmitted bits and parity match the values latched at acceptance.
